// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller:
// default geometry and output-buffer state encodings.
package fifo_rd_ctrl_pkg;

   localparam int DEF_DEEP  = 8;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_SYNC  = 2;
   localparam int DEF_AE    = 2;

   localparam int OB_DEPTH  = 2;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } ob_state_e;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Memory read port plus consumer handshake of the read controller.
// master = controller side, slave = memory/consumer side.
interface fifo_rd_ctrl_if #(
   parameter int DEEP  = 8,
   parameter int WIDTH = 8
);

   logic             pop;
   logic [DEEP-1:0]  mem_raddr;
   logic [WIDTH-1:0] mem_rdata;
   logic             en;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;

   modport master (
      output pop,
      output mem_raddr,
      output dout,
      output dout_valid,
      input  mem_rdata,
      input  en
   );

   modport slave (
      input  pop,
      input  mem_raddr,
      input  dout,
      input  dout_valid,
      output mem_rdata,
      output en
   );

endinterface

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// Gray to binary converter; bit i is the XOR of all gray bits at or above i.
module fifo_rd_ctrl_gray2bin #(
   parameter int N = 9
) (
   input  logic [N-1:0] gray_i,
   output logic [N-1:0] bin_o
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[N-1:i];
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: read pointer, write-pointer sync, Empty/level,
// and a 2-entry first-word-fall-through buffer over a 1-cycle memory.
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int DEEP        = DEF_DEEP,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC,
   parameter int AE_THRESH   = DEF_AE
) (
   input  logic           clk,
   input  logic           arst,
   input  logic [DEEP:0]  address_w,
   output logic [DEEP:0]  address_r,
   output logic           Empty,
   output logic [DEEP:0]  level,
   output logic           almost_empty,
   fifo_rd_ctrl_if.master bus
);

   localparam int PW = DEEP + 1;

   logic [PW-1:0]    rd_bin_q, rd_bin_d;
   logic [PW-1:0]    wsync;
   logic [PW-1:0]    wbin_sync;
   logic             inflight_q, inflight_d;
   ob_state_e        state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [1:0]       ob_cnt;
   logic [2:0]       occ;
   logic             accept;
   logic             ret;
   logic             pop;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign wsync = address_w;
   end else begin : g_sync
      logic [PW-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
         if (arst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
               sync_q[i] <= '0;
            end
         end else begin
            sync_q[0] <= address_w;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_q[i] <= sync_q[i-1];
            end
         end
      end

      assign wsync = sync_q[SYNC_STAGES-1];
   end

   fifo_rd_ctrl_gray2bin #(
      .N (PW)
   ) u_g2b (
      .gray_i (wsync),
      .bin_o  (wbin_sync)
   );

   assign address_r    = rd_bin_q ^ (rd_bin_q >> 1);
   assign Empty        = (address_r == wsync);
   assign level        = wbin_sync - rd_bin_q;
   assign almost_empty = (level <= PW'(AE_THRESH));

   assign ob_cnt = state_q;
   assign ret    = inflight_q;
   assign accept = bus.en & bus.dout_valid;
   assign occ    = {1'b0, ob_cnt} + {2'b00, inflight_q};

   // Buffered plus in-flight words never exceed the two buffer slots.
   assign pop = !Empty & !arst &
                ((occ < 3'(OB_DEPTH)) |
                 ((occ == 3'(OB_DEPTH)) & accept));

   assign bus.pop        = pop;
   assign bus.mem_raddr  = rd_bin_q[DEEP-1:0];
   assign bus.dout       = head_q;
   assign bus.dout_valid = (state_q != S_EMPTY);

   assign rd_bin_d   = rd_bin_q + PW'(pop);
   assign inflight_d = pop;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (state_q)
         S_EMPTY: begin
            if (ret) begin
               state_d = S_ONE;
               head_d  = bus.mem_rdata;
            end
         end
         S_ONE: begin
            if (ret && accept) begin
               head_d = bus.mem_rdata;
            end else if (ret) begin
               state_d = S_TWO;
               skid_d  = bus.mem_rdata;
            end else if (accept) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (accept) begin
               head_d = skid_q;
               if (ret) begin
                  skid_d = bus.mem_rdata;
               end else begin
                  state_d = S_ONE;
               end
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         rd_bin_q   <= '0;
         inflight_q <= 1'b0;
         state_q    <= S_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         rd_bin_q   <= rd_bin_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: DEEP=8 instance for the main flow,
// DEEP=3 instance for pointer wrap-around.
module tb_fifo_rd_ctrl;

   logic clk;
   logic arst;

   logic [8:0] address_w_a, address_r_a, level_a;
   logic       empty_a, ae_a;
   logic [3:0] address_w_b, address_r_b, level_b;
   logic       empty_b, ae_b;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [8];

   int checks;
   int errors;

   fifo_rd_ctrl_if #(.DEEP(8), .WIDTH(8)) ifa ();
   fifo_rd_ctrl_if #(.DEEP(3), .WIDTH(8)) ifb ();

   fifo_rd_ctrl #(
      .DEEP(8), .WIDTH(8), .SYNC_STAGES(2), .AE_THRESH(2)
   ) dut_a (
      .clk          (clk),
      .arst         (arst),
      .address_w    (address_w_a),
      .address_r    (address_r_a),
      .Empty        (empty_a),
      .level        (level_a),
      .almost_empty (ae_a),
      .bus          (ifa.master)
   );

   fifo_rd_ctrl #(
      .DEEP(3), .WIDTH(8), .SYNC_STAGES(2), .AE_THRESH(2)
   ) dut_b (
      .clk          (clk),
      .arst         (arst),
      .address_w    (address_w_b),
      .address_r    (address_r_b),
      .Empty        (empty_b),
      .level        (level_b),
      .almost_empty (ae_b),
      .bus          (ifb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ifa.pop) ifa.mem_rdata <= mem_a[ifa.mem_raddr];
      if (ifb.pop) ifb.mem_rdata <= mem_b[ifb.mem_raddr];
   end

   function automatic logic [8:0] g9(input logic [8:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] g4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] gb4(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [7:0] pa(input int k);
      return 8'(32'hC0 + k);
   endfunction

   function automatic logic [7:0] pb(input int k);
      return 8'(32'h30 + k);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int npop, nrx, nwr, bubble, started;
      logic [3:0] npop_b, prev_r, used;
      checks      = 0;
      errors      = 0;
      arst        = 1'b1;
      ifa.en      = 1'b0;
      ifb.en      = 1'b0;
      address_w_a = '0;
      address_w_b = '0;

      // 1: reset
      tick();
      chk("rst_pop_forced", 32'(ifa.pop), 0);
      tick();
      arst = 1'b0;
      #1;
      chk("rst_pop", 32'(ifa.pop), 0);
      chk("rst_empty", 32'(empty_a), 1);
      chk("rst_addr_r", 32'(address_r_a), 0);
      chk("rst_dv", 32'(ifa.dout_valid), 0);
      chk("rst_level", 32'(level_a), 0);
      chk("rst_ae", 32'(ae_a), 1);

      // 2: single word
      mem_a[0]    = pa(0);
      address_w_a = g9(9'd1);
      tick();
      chk("t2_pop_sync1", 32'(ifa.pop), 0);
      tick();
      chk("t2_pop", 32'(ifa.pop), 1);
      chk("t2_raddr", 32'(ifa.mem_raddr), 0);
      chk("t2_empty0", 32'(empty_a), 0);
      chk("t2_level", 32'(level_a), 1);
      chk("t2_ae", 32'(ae_a), 1);
      tick();
      chk("t2_pop_once", 32'(ifa.pop), 0);
      chk("t2_empty1", 32'(empty_a), 1);
      chk("t2_dv_inflight", 32'(ifa.dout_valid), 0);
      tick();
      chk("t2_dv", 32'(ifa.dout_valid), 1);
      chk("t2_dout", 32'(ifa.dout), 32'(pa(0)));
      tick();
      tick();
      chk("t2_hold_dv", 32'(ifa.dout_valid), 1);
      chk("t2_hold_dout", 32'(ifa.dout), 32'(pa(0)));
      chk("t2_hold_pop", 32'(ifa.pop), 0);
      ifa.en = 1'b1;
      tick();
      ifa.en = 1'b0;
      chk("t2_drained", 32'(ifa.dout_valid), 0);

      // 3: stream of 8 words, no bubbles after the first
      for (int k = 1; k <= 8; k++) mem_a[k] = pa(k);
      address_w_a = g9(9'd9);
      ifa.en  = 1'b1;
      nrx     = 1;
      bubble  = 0;
      started = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (ifa.dout_valid && nrx <= 8) begin
            chk("t3_dout", 32'(ifa.dout), 32'(pa(nrx)));
            nrx++;
            started = 1;
         end else if (started != 0 && nrx <= 8) begin
            bubble = 1;
         end
      end
      ifa.en = 1'b0;
      chk("t3_count", 32'(nrx), 9);
      chk("t3_bubble", 32'(bubble), 0);
      chk("t3_empty", 32'(empty_a), 1);

      // 4: backpressure with 10 words
      for (int k = 9; k <= 18; k++) mem_a[k] = pa(k);
      address_w_a = g9(9'd19);
      npop = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ifa.pop) npop++;
      end
      chk("t4_pops", 32'(npop), 2);
      chk("t4_obcnt", 32'(dut_a.ob_cnt), 2);
      chk("t4_level", 32'(level_a), 8);
      chk("t4_ae", 32'(ae_a), 0);
      chk("t4_dv", 32'(ifa.dout_valid), 1);
      for (int k = 0; k < 3; k++) begin
         chk("t4_head", 32'(ifa.dout), 32'(pa(9 + k)));
         ifa.en = 1'b1;
         #1;
         chk("t4_pop_on_accept", 32'(ifa.pop), 1);
         tick();
         ifa.en = 1'b0;
         #1;
         chk("t4_no_extra_pop", 32'(ifa.pop), 0);
         tick();
         tick();
      end
      chk("t4_head3", 32'(ifa.dout), 32'(pa(12)));
      chk("t4_level5", 32'(level_a), 5);

      // 5: wrap-around on the DEEP=3 instance
      ifb.en = 1'b1;
      npop_b = '0;
      nrx    = 0;
      nwr    = 0;
      prev_r = address_r_b;
      for (int c = 0; c < 200 && nrx < 19; c++) begin
         chk("t5_addr_r", 32'(address_r_b), 32'(g4(npop_b)));
         chk("t5_gray_step",
             32'($countones(address_r_b ^ prev_r) <= 1), 1);
         prev_r = address_r_b;
         if (ifb.pop) begin
            chk("t5_raddr", 32'(ifb.mem_raddr), 32'(npop_b[2:0]));
            npop_b = npop_b + 4'd1;
         end
         if (ifb.dout_valid) begin
            chk("t5_dout", 32'(ifb.dout), 32'(pb(nrx)));
            nrx++;
         end
         used = 4'(nwr) - gb4(address_r_b);
         if (nwr < 19 && used < 4'd8) begin
            mem_b[nwr % 8] = pb(nwr);
            nwr++;
            address_w_b = g4(4'(nwr));
         end
         tick();
      end
      chk("t5_count", 32'(nrx), 19);
      tick();
      tick();
      chk("t5_empty", 32'(empty_b), 1);
      chk("t5_final_ptr", 32'(address_r_b), 32'(g4(4'd3)));
      chk("t5_level", 32'(level_b), 0);
      chk("t5_ae", 32'(ae_b), 1);

      // 6: reset with a word buffered and a memory return pending
      ifa.en = 1'b1;
      #1;
      chk("t6_pop_pre", 32'(ifa.pop), 1);
      tick();
      chk("t6_inflight", 32'(dut_a.inflight_q), 1);
      arst = 1'b1;
      #1;
      chk("t6_pop_forced", 32'(ifa.pop), 0);
      tick();
      arst   = 1'b0;
      ifa.en = 1'b0;
      #1;
      chk("t6_dv", 32'(ifa.dout_valid), 0);
      chk("t6_pop", 32'(ifa.pop), 0);
      chk("t6_addr_r", 32'(address_r_a), 0);
      chk("t6_empty", 32'(empty_a), 1);
      tick();
      chk("t6_ret_dropped", 32'(ifa.dout_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
